// File: rtl/fp_align_add.sv
// fp_align_add: alignment-and-add stage of the binary32 adder.
//
// Accepts an operand pair over a valid/ready handshake, classifies both
// operands, puts the larger magnitude first, right-shifts the smaller
// mantissa a few bits per cycle (collecting a sticky bit), then adds or
// subtracts. The registered result is held until the normalize/round stage
// takes it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   A, B                  binary32 operands
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   alignedResult         32-bit sum/difference, hidden 1 at bit 31,
//                         bits [7:0] are extension bits
//   carryOut, sticky      carry of the add, OR of bits shifted past bit 0
//   exponentOut           biased exponent of the larger operand
//   alignedSign           sign of the result
//   ANaN..Bzero           operand classification flags
//   signA, signB          sign bits of the captured operands
//   outA, outB            captured operands, unmodified
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready = 1
// ALIGN | shifting the smaller mantissa right, up to SHIFT_PER_CYCLE/cycle
// ADD   | add/subtract aligned mantissas, load the output registers
// DONE  | result held on the outputs until out_ready

module fp_align_add #(
    parameter int SHIFT_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alignedResult,
    output logic        carryOut,
    output logic        sticky,
    output logic [7:0]  exponentOut,
    output logic        alignedSign,
    output logic        ANaN,
    output logic        BNaN,
    output logic        Ainf,
    output logic        Binf,
    output logic        Azero,
    output logic        Bzero,
    output logic        signA,
    output logic        signB,
    output logic [31:0] outA,
    output logic [31:0] outB
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] P_SPC = 6'(SHIFT_PER_CYCLE);

    state_t r_state;
    state_t w_state_nxt;

    // working registers
    logic [31:0] r_mx;
    logic [31:0] r_my;
    logic [5:0]  r_rem;
    logic        r_stk;
    logic        r_sign_x;
    logic        r_sign_y;
    logic [7:0]  r_ex;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  r_flags;

    // output registers
    logic [31:0] r_res;
    logic        r_cout;
    logic        r_sticky;
    logic [7:0]  r_exp_out;
    logic        r_sign_out;
    logic [5:0]  r_flags_out;
    logic [31:0] r_out_a;
    logic [31:0] r_out_b;

    // accept-time classification and ordering
    logic        w_accept;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [5:0]  w_flags;
    logic        w_special;
    logic        w_a_lead;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic [7:0]  w_rem_full;
    logic        w_far;
    logic [31:0] w_mx_init;
    logic [31:0] w_my_init;

    // align step
    logic [5:0]  w_step;
    logic [31:0] w_my_shift;
    logic [31:0] w_lost_mask;
    logic        w_lost;
    logic [5:0]  w_rem_nxt;

    // add step
    logic        w_same_sign;
    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [31:0] w_add_res;
    logic        w_add_cout;
    logic        w_add_sticky;
    logic        w_add_sign;

    assign w_accept = in_valid && (r_state == S_IDLE);

    assign w_a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    assign w_b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    assign w_a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    assign w_b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    // denormals flush to zero, so only the exponent matters
    assign w_a_zero = (A[30:23] == 8'h00);
    assign w_b_zero = (B[30:23] == 8'h00);
    assign w_flags   = {w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero};
    assign w_special = |w_flags;

    // comparing {exp, frac} as one unsigned field orders magnitudes; ties keep A first
    assign w_a_lead   = (A[30:0] >= B[30:0]);
    assign w_x        = w_a_lead ? A : B;
    assign w_y        = w_a_lead ? B : A;
    assign w_rem_full = w_x[30:23] - w_y[30:23];
    assign w_far      = (w_rem_full >= 8'd32);
    assign w_mx_init  = {1'b1, w_x[22:0], 8'h00};
    assign w_my_init  = {1'b1, w_y[22:0], 8'h00};

    assign w_step      = (r_rem < P_SPC) ? r_rem : P_SPC;
    assign w_my_shift  = r_my >> w_step;
    assign w_lost_mask = ~(32'hFFFF_FFFF << w_step);
    assign w_lost      = |(r_my & w_lost_mask);
    assign w_rem_nxt   = r_rem - w_step;

    // X >= Y in magnitude, so the difference never goes negative; the sticky
    // bit takes part as a 33rd bit so the borrow from it is not lost
    assign w_same_sign = (r_sign_x == r_sign_y);
    assign w_sum       = {1'b0, r_mx} + {1'b0, r_my};
    assign w_diff      = {r_mx, 1'b0} - {r_my, r_stk};

    always_comb begin
        w_add_res    = w_sum[31:0];
        w_add_cout   = w_sum[32];
        w_add_sticky = r_stk;
        w_add_sign   = r_sign_x;
        if (!w_same_sign) begin
            w_add_res    = w_diff[32:1];
            w_add_cout   = 1'b0;
            w_add_sticky = w_diff[0];
            w_add_sign   = (w_diff == 33'd0) ? 1'b0 : r_sign_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_special) begin
                        w_state_nxt = S_DONE;
                    end else if (w_far || (w_rem_full == 8'd0)) begin
                        w_state_nxt = S_ADD;
                    end else begin
                        w_state_nxt = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (w_rem_nxt == 6'd0) begin
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mx        <= 32'd0;
            r_my        <= 32'd0;
            r_rem       <= 6'd0;
            r_stk       <= 1'b0;
            r_sign_x    <= 1'b0;
            r_sign_y    <= 1'b0;
            r_ex        <= 8'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_flags     <= 6'd0;
            r_res       <= 32'd0;
            r_cout      <= 1'b0;
            r_sticky    <= 1'b0;
            r_exp_out   <= 8'd0;
            r_sign_out  <= 1'b0;
            r_flags_out <= 6'd0;
            r_out_a     <= 32'd0;
            r_out_b     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_flags <= w_flags;
                        if (w_special) begin
                            r_res       <= 32'd0;
                            r_cout      <= 1'b0;
                            r_sticky    <= 1'b0;
                            r_exp_out   <= 8'd0;
                            r_sign_out  <= 1'b0;
                            r_flags_out <= w_flags;
                            r_out_a     <= A;
                            r_out_b     <= B;
                        end else begin
                            r_mx     <= w_mx_init;
                            r_my     <= w_far ? 32'd0 : w_my_init;
                            r_stk    <= w_far;
                            r_rem    <= w_far ? 6'd0 : w_rem_full[5:0];
                            r_sign_x <= w_x[31];
                            r_sign_y <= w_y[31];
                            r_ex     <= w_x[30:23];
                        end
                    end
                end
                S_ALIGN: begin
                    r_my  <= w_my_shift;
                    r_stk <= r_stk | w_lost;
                    r_rem <= w_rem_nxt;
                end
                S_ADD: begin
                    r_res       <= w_add_res;
                    r_cout      <= w_add_cout;
                    r_sticky    <= w_add_sticky;
                    r_exp_out   <= r_ex;
                    r_sign_out  <= w_add_sign;
                    r_flags_out <= r_flags;
                    r_out_a     <= r_a;
                    r_out_b     <= r_b;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign out_valid     = (r_state == S_DONE);
    assign alignedResult = r_res;
    assign carryOut      = r_cout;
    assign sticky        = r_sticky;
    assign exponentOut   = r_exp_out;
    assign alignedSign   = r_sign_out;
    assign {ANaN, BNaN, Ainf, Binf, Azero, Bzero} = r_flags_out;
    assign signA         = r_out_a[31];
    assign signB         = r_out_b[31];
    assign outA          = r_out_a;
    assign outB          = r_out_b;

endmodule

// File: tb/tb_fp_align_add.sv
module tb_fp_align_add;

    localparam int SPC = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alignedResult;
    logic        carryOut;
    logic        sticky;
    logic [7:0]  exponentOut;
    logic        alignedSign;
    logic        ANaN, BNaN, Ainf, Binf, Azero, Bzero;
    logic        signA, signB;
    logic [31:0] outA;
    logic [31:0] outB;

    fp_align_add #(.SHIFT_PER_CYCLE(SPC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .A             (A),
        .B             (B),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alignedResult (alignedResult),
        .carryOut      (carryOut),
        .sticky        (sticky),
        .exponentOut   (exponentOut),
        .alignedSign   (alignedSign),
        .ANaN          (ANaN),
        .BNaN          (BNaN),
        .Ainf          (Ainf),
        .Binf          (Binf),
        .Azero         (Azero),
        .Bzero         (Bzero),
        .signA         (signA),
        .signB         (signB),
        .outA          (outA),
        .outB          (outB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cout;
        logic        stk;
        logic [7:0]  expo;
        logic        sgn;
        logic [5:0]  flags;   // {ANaN, BNaN, Ainf, Binf, Azero, Bzero}
        int          lat;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic cout, input logic stk,
                                input logic [7:0] expo, input logic sgn,
                                input logic [5:0] flags, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.res = res; v.cout = cout; v.stk = stk;
        v.expo = expo; v.sgn = sgn; v.flags = flags; v.lat = lat;
        return v;
    endfunction

    // one-shot reference: full-width shift, sticky from the bits that fall off
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        vec_t        v;
        logic [31:0] x, y, mx, my;
        logic [63:0] wide;
        logic [32:0] d33;
        logic        stk;
        int          d;
        v.a = a; v.b = b;
        v.flags = {(a[30:23] == 8'hFF) && (a[22:0] != 0), (b[30:23] == 8'hFF) && (b[22:0] != 0),
                   (a[30:23] == 8'hFF) && (a[22:0] == 0), (b[30:23] == 8'hFF) && (b[22:0] == 0),
                   a[30:23] == 8'h00, b[30:23] == 8'h00};
        v.res = 0; v.cout = 0; v.stk = 0; v.expo = 0; v.sgn = 0; v.lat = 1;
        if (v.flags != 0) return v;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        d  = int'(x[30:23]) - int'(y[30:23]);
        mx = {1'b1, x[22:0], 8'h00};
        my = {1'b1, y[22:0], 8'h00};
        if (d >= 32) begin
            my  = 0;
            stk = 1'b1;
        end else begin
            wide = {my, 32'h0} >> d;
            my   = wide[63:32];
            stk  = |wide[31:0];
        end
        v.lat  = (d == 0 || d >= 32) ? 2 : 2 + (d + SPC - 1) / SPC;
        v.expo = x[30:23];
        if (x[31] == y[31]) begin
            d33    = {1'b0, mx} + {1'b0, my};
            v.res  = d33[31:0];
            v.cout = d33[32];
            v.stk  = stk;
            v.sgn  = x[31];
        end else begin
            d33    = {mx, 1'b0} - {my, stk};
            v.res  = d33[32:1];
            v.stk  = d33[0];
            v.sgn  = (d33 == 0) ? 1'b0 : x[31];
        end
        return v;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        int         sel;
        sel = $urandom_range(0, 15);
        if (sel == 0)      e = 8'hFF;
        else if (sel == 1) e = 8'h00;
        else               e = 8'($urandom_range(8'h70, 8'h8F));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // drive one pair, measure latency, compare against the scoreboard, then
    // optionally hold the result under backpressure before handing it off
    task automatic run_vec(input vec_t v, input int hold);
        vec_t        e;
        int          lat;
        logic [31:0] snap_res, snap_a;
        logic [7:0]  snap_exp;
        @(negedge clk);
        in_valid = 1'b1;
        A = v.a;
        B = v.b;
        sb.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("scoreboard_depth", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", 64'(lat), 64'(e.lat));
            chk("alignedResult", 64'(alignedResult), 64'(e.res));
            chk("carryOut", 64'(carryOut), 64'(e.cout));
            chk("sticky", 64'(sticky), 64'(e.stk));
            chk("exponentOut", 64'(exponentOut), 64'(e.expo));
            chk("alignedSign", 64'(alignedSign), 64'(e.sgn));
            chk("flags", 64'({ANaN, BNaN, Ainf, Binf, Azero, Bzero}), 64'(e.flags));
            chk("signA", 64'(signA), 64'(e.a[31]));
            chk("signB", 64'(signB), 64'(e.b[31]));
            chk("outA", 64'(outA), 64'(e.a));
            chk("outB", 64'(outB), 64'(e.b));
        end
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (hold > 0) begin
            snap_res = alignedResult;
            snap_exp = exponentOut;
            snap_a   = outA;
            @(negedge clk);
            in_valid = 1'b1;   // must be ignored while DONE
            A = 32'h4049_0FDB;
            B = 32'h3F00_0000;
            repeat (hold) begin
                @(posedge clk);
                #1;
                chk("hold_out_valid", 64'(out_valid), 64'd1);
                chk("hold_in_ready", 64'(in_ready), 64'd0);
                chk("hold_result", 64'(alignedResult), 64'(snap_res));
                chk("hold_exponent", 64'(exponentOut), 64'(snap_exp));
                chk("hold_outA", 64'(outA), 64'(snap_a));
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
        chk("handoff_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 32'd0;
        B         = 32'd0;

        //        A             B             result        c  s  exp    sg flags     lat
        tbl.push_back(mk(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1, 0, 8'h7F, 0, 6'b000000, 2));
        tbl.push_back(mk(32'h3F80_0000, 32'h3080_0000, 32'h8000_0002, 0, 0, 8'h7F, 0, 6'b000000, 10));
        tbl.push_back(mk(32'h3F80_0000, 32'h2B80_0000, 32'h8000_0000, 0, 1, 8'h7F, 0, 6'b000000, 2));
        tbl.push_back(mk(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 0, 0, 8'h7F, 0, 6'b000000, 2));
        tbl.push_back(mk(32'h7FC0_0000, 32'h3F80_0000, 32'h0000_0000, 0, 0, 8'h00, 0, 6'b100000, 1));
        tbl.push_back(mk(32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 0, 0, 8'h00, 0, 6'b001100, 1));
        tbl.push_back(mk(32'h3F80_0000, 32'hBF00_0001, 32'h3FFF_FF80, 0, 0, 8'h7F, 0, 6'b000000, 3));
        tbl.push_back(mk(32'h3F80_0000, 32'hC000_0000, 32'h4000_0000, 0, 0, 8'h80, 1, 6'b000000, 3));
        tbl.push_back(mk(32'h3F80_0000, 32'hBA80_0001, 32'h7FDF_FFFF, 0, 1, 8'h7F, 0, 6'b000000, 5));
        tbl.push_back(mk(32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 0, 0, 8'h00, 0, 6'b000011, 1));
        tbl.push_back(mk(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 0, 0, 8'h00, 0, 6'b000010, 1));
        for (int i = 0; i < 24; i++) begin
            tbl.push_back(model(rand_op(), rand_op()));
        end

        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_result", 64'(alignedResult), 64'd0);
        chk("reset_exponent", 64'(exponentOut), 64'd0);
        chk("reset_flags", 64'({ANaN, BNaN, Ainf, Binf, Azero, Bzero, carryOut, sticky}), 64'd0);
        chk("reset_outA", 64'(outA), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], 0);
        end

        // backpressure: multi-cycle align result held for 5 cycles
        run_vec(mk(32'h3F80_0000, 32'h3080_0000, 32'h8000_0002, 0, 0, 8'h7F, 0, 6'b000000, 10), 5);

        // asynchronous reset in the middle of ALIGN
        @(negedge clk);
        in_valid = 1'b1;
        A = 32'h3F80_0000;
        B = 32'h3080_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_result", 64'(alignedResult), 64'd0);
        chk("midreset_outA", 64'(outA), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();

        // recovery after reset
        run_vec(model(32'h4040_0000, 32'hBF80_0000), 0);
        run_vec(model(32'h3F80_0000, 32'h3F80_0000), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
